// File: rtl/trigger_capture_if.sv
// Signal bundle between the trigger/capture unit and its controller / capture FIFO.
// The unit itself connects through the slave modport.
interface trigger_capture_if #(
    parameter int DATA_WIDTH = 3,
    parameter int CNT_WIDTH  = 12
);
    logic                  sync_rst;
    logic [DATA_WIDTH-1:0] trig_mask;
    logic                  trig_rising;
    logic                  force_trig;
    logic [DATA_WIDTH-1:0] probe_in;
    logic                  fifo_wrfull;
    logic                  fifo_wrreq;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  armed;
    logic                  triggered;
    logic [CNT_WIDTH-1:0]  sample_count;
    logic [1:0]            state_debug;

    modport master (
        output sync_rst, trig_mask, trig_rising, force_trig, probe_in, fifo_wrfull,
        input  fifo_wrreq, fifo_data, armed, triggered, sample_count, state_debug
    );

    modport slave (
        input  sync_rst, trig_mask, trig_rising, force_trig, probe_in, fifo_wrfull,
        output fifo_wrreq, fifo_data, armed, triggered, sample_count, state_debug
    );
endinterface

// File: rtl/trigger_capture_unit.sv
// Waits for a masked edge trigger on synchronized probe inputs, then writes
// decimated samples into the capture FIFO until it reports write-full.
module trigger_capture_unit #(
    parameter int DATA_WIDTH = 3,
    parameter int SAMPLE_DIV = 4,
    parameter int CNT_WIDTH  = 12
) (
    input  logic              clk,
    input  logic              rst,
    trigger_capture_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_DISARMED = 2'b00,
        ST_ARMED    = 2'b01,
        ST_CAPTURE  = 2'b10,
        ST_DONE     = 2'b11
    } state_t;

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    logic [DATA_WIDTH-1:0] meta_r;
    logic [DATA_WIDTH-1:0] psync_r;
    logic [DATA_WIDTH-1:0] pprev_r;
    logic                  pvalid_r;
    state_t                state_r;
    state_t                state_s;
    logic [DIV_W-1:0]      div_cnt_r;
    logic [CNT_WIDTH-1:0]  sample_count_r;
    logic [DATA_WIDTH-1:0] edge_s;
    logic                  hit_s;
    logic                  wrreq_s;

    // Two-flop probe synchronizer plus previous-sample register, cleared by rst only.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r  <= {DATA_WIDTH{1'b0}};
            psync_r <= {DATA_WIDTH{1'b0}};
            pprev_r <= {DATA_WIDTH{1'b0}};
        end else begin
            meta_r  <= bus.probe_in;
            psync_r <= meta_r;
            pprev_r <= psync_r;
        end
    end

    // Masked edge detect on the synchronized probes.
    always_comb begin
        edge_s = {DATA_WIDTH{1'b0}};
        if (bus.trig_rising) begin
            edge_s = psync_r & ~pprev_r;
        end else begin
            edge_s = ~psync_r & pprev_r;
        end
        hit_s = |(bus.trig_mask & edge_s);
    end

    // Next-state decode; the controller disarm overrides every state.
    always_comb begin
        state_s = state_r;
        if (bus.sync_rst) begin
            state_s = ST_DISARMED;
        end else begin
            case (state_r)
                ST_DISARMED: state_s = ST_ARMED;
                ST_ARMED: begin
                    if ((hit_s & pvalid_r) | bus.force_trig) begin
                        state_s = ST_CAPTURE;
                    end else begin
                        state_s = ST_ARMED;
                    end
                end
                ST_CAPTURE: begin
                    if (bus.fifo_wrfull) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_CAPTURE;
                    end
                end
                ST_DONE: state_s = ST_DONE;
                default: state_s = ST_DISARMED;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_DISARMED;
        end else begin
            state_r <= state_s;
        end
    end

    // pvalid is low for the first ARMED cycle so a level present at arm time cannot fire.
    always_ff @(posedge clk) begin
        if (rst) begin
            pvalid_r <= 1'b0;
        end else begin
            pvalid_r <= (state_r == ST_ARMED);
        end
    end

    // Decimation counter; zero on the first CAPTURE cycle so the trigger sample is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_r <= {DIV_W{1'b0}};
        end else if (state_r != ST_CAPTURE) begin
            div_cnt_r <= {DIV_W{1'b0}};
        end else if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= {DIV_W{1'b0}};
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
        end
    end

    // Write request has zero latency to wrfull so a full FIFO never sees a write.
    assign wrreq_s = (state_r == ST_CAPTURE) & (div_cnt_r == {DIV_W{1'b0}}) & ~bus.fifo_wrfull;

    // Saturating count of words written since arm; a disarm clears it on the next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_count_r <= {CNT_WIDTH{1'b0}};
        end else if (bus.sync_rst || (state_r == ST_DISARMED)) begin
            sample_count_r <= {CNT_WIDTH{1'b0}};
        end else if (wrreq_s && (sample_count_r != CNT_MAX)) begin
            sample_count_r <= sample_count_r + CNT_WIDTH'(1);
        end else begin
            sample_count_r <= sample_count_r;
        end
    end

    assign bus.fifo_wrreq   = wrreq_s;
    assign bus.fifo_data    = pprev_r;
    assign bus.armed        = (state_r == ST_ARMED);
    assign bus.triggered    = (state_r == ST_CAPTURE) | (state_r == ST_DONE);
    assign bus.sample_count = sample_count_r;
    assign bus.state_debug  = state_r;

endmodule

// File: doc/trigger_capture_unit.md
Name: trigger_capture_unit

Overview:
- Upstream stage of the FIFO-to-UART controller. It watches the probe inputs and waits for a masked edge trigger. It then writes decimated samples into the capture FIFO until the FIFO reports write-full.
- The controller drives `sync_rst` high outside its IDLE state. This disarms the unit until the FIFO has been drained over UART, after which the unit re-arms.

Parameters:
- DATA_WIDTH, 3, probe/sample width; also the width of trig_mask.
- SAMPLE_DIV, 4, clk cycles per captured sample; legal range 1..65535.
- CNT_WIDTH, 12, width of the written-sample counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- sync_rst  in  1  controller disarm; synchronous, active-high, same priority as rst on FSM state
- trig_mask  in  DATA_WIDTH  1 = channel may trigger
- trig_rising  in  1  1 = rising-edge trigger, 0 = falling-edge trigger
- force_trig  in  1  immediate trigger while ARMED
- probe_in  in  DATA_WIDTH  asynchronous probe pins
- fifo_wrfull  in  1  FIFO write-full flag
- fifo_wrreq  out  1  FIFO write request
- fifo_data  out  DATA_WIDTH  FIFO write data
- armed  out  1  high in ARMED
- triggered  out  1  high in CAPTURE or DONE
- sample_count  out  CNT_WIDTH  words written since arm; saturates at all-ones
- state_debug  out  2  DISARMED=00, ARMED=01, CAPTURE=10, DONE=11

Behaviour:
- Synchronizer: probe_in passes through 2 flops to give `psync`. A third register, `pprev`, holds the previous `psync`.
  - All three registers are always clocked.
  - All three are cleared by rst only.
- Edge detect (combinational):
  - `hit = |(trig_mask & (trig_rising ? (psync & ~pprev) : (~psync & pprev)))`.
  - `hit` is qualified by `pvalid`. `pvalid` clears on entry to ARMED and sets one cycle later, so a level already present at arm time never triggers.
- Reset values (rst): state DISARMED; fifo_wrreq 0; fifo_data 0; armed 0; triggered 0; sample_count 0; div_cnt 0; pvalid 0.
- FSM, with rst or sync_rst taking priority:
  - Any state → DISARMED on the next clk.
  - DISARMED: sample_count and div_cnt held at 0. Goes to ARMED when sync_rst is low.
  - ARMED: if `(hit & pvalid) | force_trig`, go to CAPTURE with div_cnt = 0.
  - CAPTURE:
    - div_cnt counts 0..SAMPLE_DIV-1 and wraps.
    - fifo_wrreq = (state==CAPTURE) & (div_cnt==0) & ~fifo_wrfull. It is decoded combinationally from registers, so it has zero latency relative to wrfull.
    - fifo_data = pprev, so the first word written is the sample that caused the trigger.
    - If fifo_wrfull is high in CAPTURE, go to DONE; no write is issued that cycle.
  - DONE: no writes. Stays until sync_rst or rst.
- Latency:
  - Probe pin to `psync`: 2 clk.
  - Trigger edge to first fifo_wrreq: 1 clk after the ARMED→CAPTURE transition.
  - Subsequent writes occur every SAMPLE_DIV clk.
  - SAMPLE_DIV=1 gives a write every cycle.
- sample_count increments by 1 on each cycle with fifo_wrreq=1, saturating at 2^CNT_WIDTH-1.
- Boundaries:
  - trig_mask=0 with force_trig low: stays ARMED indefinitely.
  - force_trig and hit in the same cycle: a single trigger.
  - FIFO already full at trigger: CAPTURE lasts 1 cycle, zero writes, then DONE.
  - sync_rst mid-capture: the write decoded in that same cycle is still issued if its conditions hold; state is DISARMED next cycle, and sample_count clears there.
  - Re-arm after DONE requires sync_rst high for at least 1 cycle, then low.

Test Plan:
- Rising trigger: rst, then sync_rst=0, trig_mask=001, trig_rising=1, SAMPLE_DIV=4, FIFO not full, probe_in 000→001 → fifo_wrreq pulses every 4 clk. The first fifo_data is 001. armed falls and triggered rises on the trigger.
- Mask/edge filter: trig_mask=010, toggle bit0 and bit2, and apply a falling edge on bit1 with trig_rising=1 → stays ARMED with no writes. A rising edge on bit1 → CAPTURE.
- Level at arm: probe_in=111 held before sync_rst falls → no trigger. Dropping to 000 then 111 → trigger.
- Full stop: assert fifo_wrfull after 5 writes → exactly 5 wrreq pulses, state_debug=11, sample_count=5, no further writes.
- Full at trigger / force: fifo_wrfull=1, force_trig=1 in ARMED → CAPTURE for 1 cycle, 0 writes, then DONE.
- Disarm mid-capture: sync_rst=1 during CAPTURE → state_debug=00 and sample_count=0 next cycle. After sync_rst=0 → ARMED, and a new trigger captures normally.
